// File: rtl/fu_issue_arbiter.sv
// ============================================================================
// fu_issue_arbiter : round-robin issue-port arbiter with multi-cycle occupancy
// Rev 1.0
// ============================================================================
`default_nettype none

module fu_issue_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int LAT_W   = 5,
  parameter int IDX_W   = $clog2(NUM_REQ)
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NUM_REQ-1:0]       req_valid,
  input  logic [NUM_REQ*LAT_W-1:0] req_lat,
  input  logic                     fu_stall,
  input  logic                     flush,
  output logic [NUM_REQ-1:0]       grant,
  output logic                     fu_valid,
  output logic [IDX_W-1:0]         fu_sel,
  output logic                     busy
);

  localparam logic [IDX_W:0]   c_NUM_REQ = (IDX_W+1)'(NUM_REQ);
  localparam logic [IDX_W-1:0] c_LAST    = IDX_W'(NUM_REQ - 1);

  logic [IDX_W-1:0] rr_ptr_q, rr_ptr_d;
  logic [LAT_W-1:0] busy_cnt_q, busy_cnt_d;

  logic [LAT_W-1:0] w_lat [NUM_REQ];
  logic             w_found;
  logic [IDX_W-1:0] w_win;
  logic [LAT_W-1:0] w_win_lat;
  logic             w_busy;
  logic             w_fire;

  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_lat
    assign w_lat[gi] = req_lat[gi*LAT_W +: LAT_W];
  end

  // Scan from rr_ptr upward; wrap by compare so non-power-of-two sizes work.
  always_comb begin
    logic [IDX_W:0] cand;
    cand    = '0;
    w_found = 1'b0;
    w_win   = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      cand = {1'b0, rr_ptr_q} + (IDX_W+1)'(k);
      if (cand >= c_NUM_REQ) cand = cand - c_NUM_REQ;
      if (!w_found && req_valid[cand[IDX_W-1:0]]) begin
        w_found = 1'b1;
        w_win   = cand[IDX_W-1:0];
      end
    end
  end

  assign w_win_lat = w_lat[w_win];
  assign w_busy    = (busy_cnt_q != '0);
  assign w_fire    = rst_n && w_found && !w_busy && !fu_stall && !flush;

  assign grant    = w_fire ? (NUM_REQ'(1) << w_win) : '0;
  assign fu_valid = w_fire;
  assign fu_sel   = w_fire ? w_win : '0;
  assign busy     = rst_n && w_busy;

  always_comb begin
    rr_ptr_d   = rr_ptr_q;
    busy_cnt_d = busy_cnt_q;
    if (w_fire) begin
      rr_ptr_d = (w_win == c_LAST) ? '0 : w_win + IDX_W'(1);
    end
    if (flush) begin
      busy_cnt_d = '0;
    end else if (w_fire && (w_win_lat >= LAT_W'(2))) begin
      busy_cnt_d = w_win_lat - LAT_W'(1);
    end else if (w_busy) begin
      busy_cnt_d = busy_cnt_q - LAT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr_q   <= '0;
      busy_cnt_q <= '0;
    end else begin
      rr_ptr_q   <= rr_ptr_d;
      busy_cnt_q <= busy_cnt_d;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_fu_issue_arbiter.sv
// ============================================================================
// tb_fu_issue_arbiter : scoreboard bench for fu_issue_arbiter (4- and 3-way)
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_fu_issue_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  v4;
  logic [19:0] lat4;
  logic        stall;
  logic        flush;
  logic [3:0]  grant4;
  logic        fv4;
  logic [1:0]  sel4;
  logic        busy4;

  logic [2:0]  v3;
  logic [14:0] lat3;
  logic [2:0]  grant3;
  logic        fv3;
  logic [1:0]  sel3;
  logic        busy3;

  int checks = 0;
  int errors = 0;

  logic [7:0] sb4 [$];
  logic [6:0] sb3 [$];

  always #5 clk = ~clk;

  fu_issue_arbiter #(.NUM_REQ(4), .LAT_W(5)) u_dut4 (
    .clk(clk), .rst_n(rst_n), .req_valid(v4), .req_lat(lat4),
    .fu_stall(stall), .flush(flush),
    .grant(grant4), .fu_valid(fv4), .fu_sel(sel4), .busy(busy4)
  );

  fu_issue_arbiter #(.NUM_REQ(3), .LAT_W(5)) u_dut3 (
    .clk(clk), .rst_n(rst_n), .req_valid(v3), .req_lat(lat3),
    .fu_stall(1'b0), .flush(1'b0),
    .grant(grant3), .fu_valid(fv3), .fu_sel(sel3), .busy(busy3)
  );

  wire [7:0] obs4 = {grant4, fv4, sel4, busy4};
  wire [6:0] obs3 = {grant3, fv3, sel3, busy3};

  // Expected observation word; sel < 0 means no grant.
  function automatic logic [7:0] ex4(int sel, bit b);
    logic [3:0] g;
    g = (sel < 0) ? 4'b0 : (4'b1 << sel);
    return {g, (sel >= 0), (sel < 0) ? 2'd0 : 2'(sel), b};
  endfunction

  function automatic logic [6:0] ex3(int sel, bit b);
    logic [2:0] g;
    g = (sel < 0) ? 3'b0 : (3'b1 << sel);
    return {g, (sel >= 0), (sel < 0) ? 2'd0 : 2'(sel), b};
  endfunction

  function automatic logic [19:0] pk(int l0, int l1, int l2, int l3);
    return {5'(l3), 5'(l2), 5'(l1), 5'(l0)};
  endfunction

  task automatic drive4(logic [3:0] v, logic [19:0] l, bit st, bit fl, logic [7:0] e);
    v4    = v;
    lat4  = l;
    stall = st;
    flush = fl;
    sb4.push_back(e);
  endtask

  task automatic test_reset();
    logic [7:0] e;
    logic [6:0] e3;
    repeat (2) @(posedge clk);
    #1;
    drive4(4'hF, '0, 0, 0, 8'h00);
    v3 = 3'b111;
    sb3.push_back(7'h00);
    @(negedge clk);
    e = sb4.pop_front();
    checks++;
    if (obs4 !== e) begin errors++; $display("FAIL reset4 got %b exp %b", obs4, e); end
    e3 = sb3.pop_front();
    checks++;
    if (obs3 !== e3) begin errors++; $display("FAIL reset3 got %b exp %b", obs3, e3); end
    v4 = '0;
    v3 = '0;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_rotate();
    logic [7:0] e;
    for (int i = 0; i < 8; i++) begin
      drive4(4'hF, '0, 0, 0, ex4(i % 4, 0));
      @(negedge clk);
      e = sb4.pop_front();
      checks++;
      if (obs4 !== e) begin errors++; $display("FAIL rotate[%0d] got %b exp %b", i, obs4, e); end
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_wrap3();
    logic [6:0] e;
    v4 = '0;
    for (int i = 0; i < 5; i++) begin
      v3 = 3'b111;
      sb3.push_back(ex3(i % 3, 0));
      @(negedge clk);
      e = sb3.pop_front();
      checks++;
      if (obs3 !== e) begin errors++; $display("FAIL wrap3[%0d] got %b exp %b", i, obs3, e); end
      @(posedge clk);
      #1;
    end
    v3 = '0;
  endtask

  task automatic test_multicycle();
    logic [7:0] e;
    for (int c = 0; c < 11; c++) begin
      if (c == 0 || c == 5) drive4(4'b0100, pk(31, 31, 5, 31), 0, 0, ex4(2, 0));
      else if (c < 5)       drive4(4'b0100, pk(31, 31, 5, 31), 0, 0, ex4(-1, 1));
      else if (c < 10)      drive4(4'b0000, pk(31, 31, 5, 31), 0, 0, ex4(-1, 1));
      else                  drive4(4'b0000, pk(31, 31, 5, 31), 0, 0, ex4(-1, 0));
      @(negedge clk);
      e = sb4.pop_front();
      checks++;
      if (obs4 !== e) begin errors++; $display("FAIL multicycle[%0d] got %b exp %b", c, obs4, e); end
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_stall();
    logic [7:0] e;
    for (int c = 0; c < 5; c++) begin
      if (c == 0)      drive4(4'b1000, '0, 0, 0, ex4(3, 0));
      else if (c < 4)  drive4(4'b0110, '0, 1, 0, ex4(-1, 0));
      else             drive4(4'b0110, '0, 0, 0, ex4(1, 0));
      @(negedge clk);
      e = sb4.pop_front();
      checks++;
      if (obs4 !== e) begin errors++; $display("FAIL stall[%0d] got %b exp %b", c, obs4, e); end
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_flush();
    logic [7:0] e;
    for (int c = 0; c < 4; c++) begin
      case (c)
        0:       drive4(4'b0001, pk(8, 0, 0, 0), 0, 0, ex4(0, 0));
        1:       drive4(4'b0001, pk(8, 0, 0, 0), 0, 0, ex4(-1, 1));
        2:       drive4(4'b1111, pk(8, 0, 0, 0), 0, 1, ex4(-1, 1));
        default: drive4(4'b1111, '0, 0, 0, ex4(1, 0));
      endcase
      @(negedge clk);
      e = sb4.pop_front();
      checks++;
      if (obs4 !== e) begin errors++; $display("FAIL flush[%0d] got %b exp %b", c, obs4, e); end
      @(posedge clk);
      #1;
    end
    flush = 1'b0;
  endtask

  task automatic test_busy_over_stall();
    logic [7:0] e;
    for (int c = 0; c < 4; c++) begin
      case (c)
        0:       drive4(4'b0100, pk(0, 0, 3, 0), 0, 0, ex4(2, 0));
        1:       drive4(4'b1111, '0, 1, 0, ex4(-1, 1));
        2:       drive4(4'b1111, '0, 0, 0, ex4(-1, 1));
        default: drive4(4'b1111, '0, 0, 0, ex4(3, 0));
      endcase
      @(negedge clk);
      e = sb4.pop_front();
      checks++;
      if (obs4 !== e) begin errors++; $display("FAIL busy_stall[%0d] got %b exp %b", c, obs4, e); end
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_saturate();
    logic [7:0] e;
    for (int c = 0; c < 32; c++) begin
      if (c == 0)       drive4(4'b0001, pk(31, 0, 0, 0), 0, 0, ex4(0, 0));
      else if (c < 31)  drive4(4'b0001, pk(31, 0, 0, 0), 0, 0, ex4(-1, 1));
      else              drive4(4'b0001, '0, 0, 0, ex4(0, 0));
      @(negedge clk);
      e = sb4.pop_front();
      checks++;
      if (obs4 !== e) begin errors++; $display("FAIL saturate[%0d] got %b exp %b", c, obs4, e); end
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_async_reset();
    logic [7:0] e;
    drive4(4'b0010, pk(0, 4, 0, 0), 0, 0, ex4(1, 0));
    @(negedge clk);
    e = sb4.pop_front();
    checks++;
    if (obs4 !== e) begin errors++; $display("FAIL arst_grant got %b exp %b", obs4, e); end
    @(posedge clk);
    #1;
    drive4(4'b1111, '0, 0, 0, ex4(-1, 1));
    #1;
    e = sb4.pop_front();
    checks++;
    if (obs4 !== e) begin errors++; $display("FAIL arst_busy got %b exp %b", obs4, e); end
    rst_n = 1'b0;
    sb4.push_back(8'h00);
    #1;
    e = sb4.pop_front();
    checks++;
    if (obs4 !== e) begin errors++; $display("FAIL arst_drop got %b exp %b", obs4, e); end
    @(negedge clk);
    rst_n = 1'b1;
    drive4(4'b0110, '0, 0, 0, ex4(1, 0));
    #1;
    e = sb4.pop_front();
    checks++;
    if (obs4 !== e) begin errors++; $display("FAIL arst_first got %b exp %b", obs4, e); end
    @(posedge clk);
    #1;
    drive4(4'b0110, '0, 0, 0, ex4(2, 0));
    @(negedge clk);
    e = sb4.pop_front();
    checks++;
    if (obs4 !== e) begin errors++; $display("FAIL arst_next got %b exp %b", obs4, e); end
  endtask

  initial begin
    rst_n = 1'b0;
    v4    = '0;
    lat4  = '0;
    stall = 1'b0;
    flush = 1'b0;
    v3    = '0;
    lat3  = '0;
    test_reset();
    test_rotate();
    test_wrap3();
    test_multicycle();
    test_stall();
    test_flush();
    test_busy_over_stall();
    test_saturate();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/fu_issue_arbiter.md
# fu_issue_arbiter

Round-robin scheduler that shares one execution-unit issue port among `NUM_REQ` issue queues. Each cycle it picks at most one ready queue, raises that queue's one-hot `grant`, and the queue uses it as its `dequeue`. It also blocks the port while a multi-cycle (non-pipelined) operation occupies the unit. It sits between the issue queues' `ready_out` outputs and the functional-unit input register, and observes flush and backpressure.

## Interface
Parameters:
- `NUM_REQ`, default 4: number of requesting issue queues (2..16, not necessarily a power of two).
- `LAT_W`, default 5: width of each per-request occupancy latency field.
- `IDX_W`, default $clog2(NUM_REQ): width of the winner index.

Ports:
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `req_valid`  in  NUM_REQ  bit i = queue i has an issuable entry (its `ready_out`).
- `req_lat`  in  NUM_REQ*LAT_W  field i = cycles the unit is occupied by queue i's head op; values 0 and 1 mean pipelined.
- `fu_stall`  in  1  unit or CDB cannot accept an op this cycle.
- `flush`  in  1  late flush or mispredict recovery; kills the current grant and any occupancy.
- `grant`  out  NUM_REQ  one-hot or zero; bit i = dequeue queue i this cycle.
- `fu_valid`  out  1  an op is launched into the unit this cycle (= |grant).
- `fu_sel`  out  IDX_W  index of the granted queue; 0 when `fu_valid`=0.
- `busy`  out  1  unit is occupied by an earlier multi-cycle op.

## Operation
- State:
  - `rr_ptr` [IDX_W]: highest-priority requester.
  - `busy_cnt` [LAT_W]: remaining blocked cycles.
- `busy` = (`busy_cnt` != 0).
- `grant_en` = !`busy` && !`fu_stall` && !`flush`.
- Winner selection, when `grant_en`:
  - Scan indices `rr_ptr`, `rr_ptr`+1, … mod NUM_REQ.
  - The first i with `req_valid`[i] wins: `grant`[i]=1, `fu_sel`=i.
  - If no bit is set, `grant`=0.
- Pointer update on a grant: `rr_ptr` <= winner+1, wrapping NUM_REQ-1 -> 0 with an explicit compare (not a power-of-two mask). With no grant, `rr_ptr` holds.
- Occupancy:
  - Grant with L = `req_lat`[winner] ≥ 2: `busy_cnt` <= L-1.
  - Otherwise, if `busy_cnt` != 0: `busy_cnt` <= `busy_cnt`-1. The counter decrements regardless of `fu_stall`.
- Flush: `grant` is forced to 0 in that cycle, `busy_cnt` <= 0, and `rr_ptr` holds.
- `req_lat` fields of non-winning requesters are ignored.
- Saturation: L = 2^LAT_W-1 is legal and gives 2^LAT_W-2 blocked cycles.

## Timing
- Reset (`rst_n`=0, asynchronous):
  - `rr_ptr`=0, `busy_cnt`=0.
  - All outputs read 0: `grant`, `fu_valid`, `fu_sel` and `busy` are gated low while `rst_n`=0.
- Grant is combinational: it is valid in the same cycle as `req_valid`, and the requester dequeues at that edge.
- Zero-cycle arbitration latency; throughput is one grant per cycle for pipelined ops.
- After a grant with L ≥ 2, the next grant is possible L cycles later. Example: grant at cycle t with L=4 -> `busy` high in t+1..t+3 -> next grant at t+4 at the earliest.
- Simultaneous events:
  - `flush` takes priority over everything.
  - `busy` takes priority over `fu_stall`.
  - `fu_stall` with `busy`=0 only blocks the grant; it does not advance `rr_ptr`.
- Reset deasserting mid-occupancy is not possible (state is cleared). Reset asserting mid-cycle drops `grant` immediately.
- `req_valid` may change every cycle. No request is held or latched by this block.

## Test plan
- Reset then all `req_valid`=4'b1111, `req_lat`=0, NUM_REQ=4, 8 cycles -> grants rotate 0,1,2,3,0,1,2,3; `busy` stays 0.
- NUM_REQ=3, `req_valid`=3'b111 constant -> `fu_sel` sequence 0,1,2,0,1 (wrap with non-power-of-two size).
- Only queue 2 requests with `req_lat`=5 at t -> grant at t, `busy`=1 in t+1..t+4 with no grant despite `req_valid`, grant again at t+5.
- `fu_stall`=1 for 3 cycles with `req_valid`=4'b0110 and `rr_ptr`=0 -> no grant and `rr_ptr` stays 0; first cycle after stall grants queue 1.
- Grant queue 0 with L=8, `flush` at t+2 -> `grant`=0 at t+2, `busy`=0 at t+3, grant resumes at t+3 from `rr_ptr`=1.
- Assert `rst_n`=0 asynchronously mid-occupancy (`busy_cnt`=3) -> `grant`/`busy`/`fu_valid`/`fu_sel` drop to 0 before the next edge; after release the first grant goes to the lowest-index requester.
